i2c_req_arbiter: RTL and testbench

// Shares one i2c_master among NREQ requesters. Arbitrates round-robin and latches the winner's command.

---
 rtl/i2c_req_arbiter_if.sv | 40 ++++
 rtl/i2c_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_req_arbiter_if.sv
// Requester-side and i2c_master-side signals of the shared-master arbiter.
// master modport = arbiter view, slave modport = clients plus the i2c_master.
interface i2c_req_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0][6:0]  req_addr;
   logic [NREQ-1:0]       req_rw;
   logic [NREQ-1:0][39:0] req_data;
   logic [NREQ-1:0][3:0]  req_nbyte;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       rsp_valid;
   logic [7:0]            rsp_data;
   logic [NREQ-1:0]       done;
   logic [NREQ-1:0]       err;
   logic [6:0]            m_addr;
   logic                  m_rw;
   logic [39:0]           m_data_w;
   logic [3:0]            m_N_byte;
   logic                  m_start;
   logic [7:0]            m_data_out;
   logic                  m_valid_out;
   logic                  m_busy;
   logic                  m_erro_addr;

   modport master (
      input  req_valid, req_addr, req_rw, req_data, req_nbyte,
      input  m_data_out, m_valid_out, m_busy, m_erro_addr,
      output req_ready, grant, rsp_valid, rsp_data, done, err,
      output m_addr, m_rw, m_data_w, m_N_byte, m_start
   );

   modport slave (
      output req_valid, req_addr, req_rw, req_data, req_nbyte,
      output m_data_out, m_valid_out, m_busy, m_erro_addr,
      input  req_ready, grant, rsp_valid, rsp_data, done, err,
      input  m_addr, m_rw, m_data_w, m_N_byte, m_start
   );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NREQ requesters.
// Optional I2C_ARB_TIMEOUT_EN adds a LAUNCH/RUN watchdog and the DRAIN state.
module i2c_req_arbiter #(
   parameter int NREQ = 4
`ifdef I2C_ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 65535
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   i2c_req_arbiter_if.master  bus
);
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      RUN    = 3'd2,
      DONE   = 3'd3
`ifdef I2C_ARB_TIMEOUT_EN
      , DRAIN = 3'd4
`endif
   } state_t;

   state_t          state;
   logic [OW-1:0]   owner, rr, win;
   logic            win_any, win_bad;
   logic            err_flag;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0]     to_cnt;
`endif

   // Scan downward so the last hit is the first valid requester above rr.
   always_comb begin
      win_any = 1'b0;
      win     = '0;
      for (int i = NREQ; i >= 1; i--) begin
         if (bus.req_valid[(int'(rr) + i) % NREQ]) begin
            win_any = 1'b1;
            win     = OW'((int'(rr) + i) % NREQ);
         end
      end
      win_bad = (bus.req_rw[win] && bus.req_nbyte[win] == 4'd0) ||
                (!bus.req_rw[win] && bus.req_nbyte[win] > 4'd4);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         owner         <= '0;
         rr            <= OW'(NREQ - 1);
         err_flag      <= 1'b0;
         bus.req_ready <= '0;
         bus.grant     <= '0;
         bus.rsp_valid <= '0;
         bus.rsp_data  <= '0;
         bus.done      <= '0;
         bus.err       <= '0;
         bus.m_addr    <= '0;
         bus.m_rw      <= 1'b0;
         bus.m_data_w  <= '0;
         bus.m_N_byte  <= '0;
         bus.m_start   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
         to_cnt        <= '0;
`endif
      end else begin
         bus.req_ready <= '0;
         bus.rsp_valid <= '0;
         bus.done      <= '0;
         bus.err       <= '0;
         case (state)
            IDLE: begin
               if (win_any) begin
                  owner         <= win;
                  bus.req_ready <= ONE << win;
                  bus.grant     <= ONE << win;
                  bus.m_addr    <= bus.req_addr[win];
                  bus.m_rw      <= bus.req_rw[win];
                  bus.m_data_w  <= bus.req_data[win];
                  bus.m_N_byte  <= bus.req_nbyte[win];
                  if (win_bad) begin
                     err_flag <= 1'b1;
                     state    <= DONE;
                  end else begin
                     bus.m_start <= 1'b1;
                     state       <= LAUNCH;
                  end
`ifdef I2C_ARB_TIMEOUT_EN
                  to_cnt <= '0;
`endif
               end
            end
            LAUNCH, RUN: begin
`ifdef I2C_ARB_TIMEOUT_EN
               to_cnt <= to_cnt + 16'd1;
               if (to_cnt == TO_LAST) begin
                  bus.done    <= ONE << owner;
                  bus.err     <= ONE << owner;
                  bus.m_start <= 1'b0;
                  bus.grant   <= '0;
                  err_flag    <= 1'b0;
                  state       <= DRAIN;
               end else
`endif
               if (state == LAUNCH) begin
                  if (bus.m_busy) begin
                     bus.m_start <= 1'b0;
                     state       <= RUN;
                  end
               end else begin
                  // A byte arriving with the busy drop is still forwarded.
                  if (bus.m_valid_out) begin
                     bus.rsp_valid <= ONE << owner;
                     bus.rsp_data  <= bus.m_data_out;
                  end
                  if (bus.m_erro_addr) err_flag <= 1'b1;
                  if (!bus.m_busy) state <= DONE;
               end
            end
            DONE: begin
               bus.done     <= ONE << owner;
               bus.err      <= err_flag ? (ONE << owner) : '0;
               rr           <= owner;
               err_flag     <= 1'b0;
               bus.grant    <= '0;
               bus.m_addr   <= '0;
               bus.m_rw     <= 1'b0;
               bus.m_data_w <= '0;
               bus.m_N_byte <= '0;
               state        <= IDLE;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            DRAIN: begin
               // Abort already reported; just wait for the master to let go.
               if (!bus.m_busy) begin
                  rr           <= owner;
                  bus.m_addr   <= '0;
                  bus.m_rw     <= 1'b0;
                  bus.m_data_w <= '0;
                  bus.m_N_byte <= '0;
                  state        <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter; the timeout section is built only
// when I2C_ARB_TIMEOUT_EN is defined (TIMEOUT_CYC=16 there).
module tb_i2c_req_arbiter;
   localparam int NREQ = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   i2c_req_arbiter_if #(.NREQ(NREQ)) bus ();

   i2c_req_arbiter #(
      .NREQ(NREQ)
`ifdef I2C_ARB_TIMEOUT_EN
      , .TIMEOUT_CYC(16)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [6:0] a, input logic rw,
                          input logic [39:0] d, input logic [3:0] n);
      bus.req_addr[r]  = a;
      bus.req_rw[r]    = rw;
      bus.req_data[r]  = d;
      bus.req_nbyte[r] = n;
      bus.req_valid[r] = 1'b1;
   endtask

   // IDLE edge: winner r gets ready/grant; start only for a legal command.
   task automatic grant_chk(input string tag, input int r, input logic legal,
                            input logic [6:0] a, input logic [3:0] n);
      tick();
      chk({tag, ".ready"}, 64'(bus.req_ready), 64'(1 << r));
      chk({tag, ".grant"}, 64'(bus.grant), 64'(1 << r));
      chk({tag, ".start"}, 64'(bus.m_start), 64'(legal));
      chk({tag, ".addr"},  64'(bus.m_addr), 64'(a));
      chk({tag, ".nbyte"}, 64'(bus.m_N_byte), 64'(n));
      chk({tag, ".done0"}, 64'(bus.done), 64'd0);
      bus.req_valid[r] = 1'b0;
   endtask

   task automatic busy_up(input string tag);
      tick();
      chk({tag, ".start_hold"}, 64'(bus.m_start), 64'd1);
      chk({tag, ".ready_pulse"}, 64'(bus.req_ready), 64'd0);
      bus.m_busy = 1'b1;
      tick();
      chk({tag, ".start_drop"}, 64'(bus.m_start), 64'd0);
   endtask

   task automatic finish(input string tag, input int r, input logic e);
      bus.m_busy = 1'b0;
      tick();
      chk({tag, ".done_wait"}, 64'(bus.done), 64'd0);
      tick();
      chk({tag, ".done"},  64'(bus.done), 64'(1 << r));
      chk({tag, ".err"},   64'(bus.err), e ? 64'(1 << r) : 64'd0);
      chk({tag, ".ungrant"}, 64'(bus.grant), 64'd0);
      chk({tag, ".clr"},   64'(bus.m_addr), 64'd0);
   endtask

   task automatic rd_byte(input string tag, input int r, input logic [7:0] b, input logic last);
      bus.m_valid_out = 1'b1;
      bus.m_data_out  = b;
      if (last) bus.m_busy = 1'b0;
      tick();
      bus.m_valid_out = 1'b0;
      chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(1 << r));
      chk({tag, ".rsp_data"},  64'(bus.rsp_data), 64'(b));
   endtask

   initial begin
      bus.req_valid = '0;  bus.req_addr = '0;  bus.req_rw = '0;
      bus.req_data  = '0;  bus.req_nbyte = '0;
      bus.m_data_out = '0; bus.m_valid_out = 1'b0;
      bus.m_busy = 1'b0;   bus.m_erro_addr = 1'b0;

      #12;
      chk("rst.grant", 64'(bus.grant), 64'd0);
      chk("rst.ready", 64'(bus.req_ready), 64'd0);
      chk("rst.start", 64'(bus.m_start), 64'd0);
      chk("rst.done_err", 64'({bus.done, bus.err, bus.rsp_valid}), 64'd0);
      chk("rst.payload", 64'({bus.m_addr, bus.m_rw, bus.m_N_byte}), 64'd0);
      chk("rst.data_w", 64'(bus.m_data_w), 64'd0);
      rst_n = 1'b1;

      // Contention from reset: req0 first, then req2; spec write vector on req0.
      set_req(0, 7'h50, 1'b0, 40'h10AABB0000, 4'd2);
      set_req(2, 7'h22, 1'b0, 40'h0011000000, 4'd1);
      grant_chk("wr0", 0, 1'b1, 7'h50, 4'd2);
      chk("wr0.data_w", 64'(bus.m_data_w), 64'h10AABB0000);
      chk("wr0.rw", 64'(bus.m_rw), 64'd0);
      busy_up("wr0");
      tick();
      chk("wr0.grant_run", 64'(bus.grant), 64'd1);
      chk("wr0.data_hold", 64'(bus.m_data_w), 64'h10AABB0000);
      finish("wr0", 0, 1'b0);
      grant_chk("wr2", 2, 1'b1, 7'h22, 4'd1);
      busy_up("wr2");
      finish("wr2", 2, 1'b0);

      // req0 alone moves the pointer to 0, so req1 beats req0 next.
      set_req(0, 7'h50, 1'b0, 40'h10AABB0000, 4'd2);
      grant_chk("wr0b", 0, 1'b1, 7'h50, 4'd2);
      busy_up("wr0b");
      finish("wr0b", 0, 1'b0);

      set_req(0, 7'h51, 1'b0, 40'h0102030405, 4'd4);
      set_req(1, 7'h3C, 1'b1, 40'h0, 4'd3);
      grant_chk("rd1", 1, 1'b1, 7'h3C, 4'd3);
      chk("rd1.rw", 64'(bus.m_rw), 64'd1);
      busy_up("rd1");
      rd_byte("rd1.b0", 1, 8'hA1, 1'b0);
      tick();
      chk("rd1.pulse", 64'(bus.rsp_valid), 64'd0);
      rd_byte("rd1.b1", 1, 8'hB2, 1'b0);
      rd_byte("rd1.b2", 1, 8'hC3, 1'b1);
      chk("rd1.done_after_byte", 64'(bus.done), 64'd0);
      tick();
      chk("rd1.done", 64'(bus.done), 64'd2);
      chk("rd1.err", 64'(bus.err), 64'd0);
      grant_chk("wr0c", 0, 1'b1, 7'h51, 4'd4);
      chk("wr0c.data_w", 64'(bus.m_data_w), 64'h0102030405);
      busy_up("wr0c");
      finish("wr0c", 0, 1'b0);

      // Address NACK on req3.
      set_req(3, 7'h7F, 1'b0, 40'hFF00000000, 4'd1);
      grant_chk("nack", 3, 1'b1, 7'h7F, 4'd1);
      busy_up("nack");
      bus.m_erro_addr = 1'b1;
      bus.m_busy = 1'b0;
      tick();
      bus.m_erro_addr = 1'b0;
      chk("nack.wait", 64'(bus.done), 64'd0);
      tick();
      chk("nack.done", 64'(bus.done), 64'd8);
      chk("nack.err", 64'(bus.err), 64'd8);
      chk("nack.ungrant", 64'(bus.grant), 64'd0);
      tick();
      chk("nack.idle", 64'({bus.grant, bus.done, bus.err}), 64'd0);

      // Illegal commands: read of 0 bytes, write of 5 bytes.
      set_req(2, 7'h11, 1'b1, 40'h0, 4'd0);
      grant_chk("ill_rd", 2, 1'b0, 7'h11, 4'd0);
      tick();
      chk("ill_rd.done", 64'(bus.done), 64'd4);
      chk("ill_rd.err", 64'(bus.err), 64'd4);
      chk("ill_rd.start", 64'(bus.m_start), 64'd0);
      set_req(1, 7'h12, 1'b0, 40'h0, 4'd5);
      grant_chk("ill_wr", 1, 1'b0, 7'h12, 4'd5);
      tick();
      chk("ill_wr.done", 64'(bus.done), 64'd2);
      chk("ill_wr.err", 64'(bus.err), 64'd2);

      // Reset in RUN: outputs clear at once, pointer back to NREQ-1.
      set_req(1, 7'h20, 1'b0, 40'h00AA000000, 4'd1);
      grant_chk("mid", 1, 1'b1, 7'h20, 4'd1);
      busy_up("mid");
      #2 rst_n = 1'b0;
      #1;
      chk("mid.grant", 64'(bus.grant), 64'd0);
      chk("mid.payload", 64'({bus.m_addr, bus.m_N_byte, bus.m_start}), 64'd0);
      chk("mid.data_w", 64'(bus.m_data_w), 64'd0);
      bus.m_busy = 1'b0;
      #1 rst_n = 1'b1;
      set_req(0, 7'h40, 1'b0, 40'h0, 4'd1);
      set_req(1, 7'h41, 1'b0, 40'h0, 4'd1);
      grant_chk("post", 0, 1'b1, 7'h40, 4'd1);
      bus.req_valid[1] = 1'b0;
      busy_up("post");
      finish("post", 0, 1'b0);

`ifdef I2C_ARB_TIMEOUT_EN
      // m_busy never rises: abort 16 cycles after LAUNCH entry.
      set_req(2, 7'h33, 1'b0, 40'h0, 4'd1);
      grant_chk("to", 2, 1'b1, 7'h33, 4'd1);
      for (int k = 0; k < 15; k++) tick();
      chk("to.early", 64'({bus.done, bus.m_start}), 64'd1);
      tick();
      chk("to.done", 64'(bus.done), 64'd4);
      chk("to.err", 64'(bus.err), 64'd4);
      chk("to.start", 64'(bus.m_start), 64'd0);
      chk("to.ungrant", 64'(bus.grant), 64'd0);
      tick();
      chk("to.drain", 64'(bus.done), 64'd0);
      set_req(0, 7'h01, 1'b1, 40'h0, 4'd0);
      grant_chk("to.idle", 0, 1'b0, 7'h01, 4'd0);
      tick();
      chk("to.idle_done", 64'(bus.done), 64'd1);
`endif

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
